// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-add multiply sequencer: the datapath ALU
// opcode set and the sequencer state encoding.
package alu_mul_seq_pkg;

  // ALU opcodes as decoded by the shared datapath ALU.
  typedef enum logic [3:0] {
    AND = 4'b0000,
    OR  = 4'b0001,
    ADD = 4'b0010,
    LSH = 4'b0011,
    RSH = 4'b0100,
    SUB = 4'b0110,
    SLT = 4'b0111,
    NOR = 4'b1100
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ADD_S,
    SHL_S,
    SHR_S,
    DONE_S
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned multiplier that borrows the shared ALU for ADD/LSH/RSH
// steps. Define ALU_MUL_EARLY_EXIT_EN to stop as soon as no multiplier bits remain.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITERS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  localparam logic [2:0] LAST_CNT = 3'(ITERS - 1);

  mul_state_t       state_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             shr_exit;
  logic             zero_start;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // alu_zero reflects the shifted multiplier during SHR: nothing left to add.
  assign shr_exit   = (cnt_q == LAST_CNT) || alu_zero;
  assign zero_start = (op_b == '0);
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
  assign shr_exit        = (cnt_q == LAST_CNT);
  assign zero_start      = 1'b0;
`endif

  always_comb begin
    alu_op = LSH;
    alu_a  = '0;
    alu_b  = '0;
    case (state_q)
      ADD_S: begin
        alu_op = ADD;
        alu_a  = prod_q;
        alu_b  = mcand_q;
      end
      SHL_S: begin
        alu_op = LSH;
        alu_a  = mcand_q;
      end
      SHR_S: begin
        alu_op = RSH;
        alu_a  = mplier_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (zero_start) begin
              state_q  <= DONE_S;
              result_q <= '0;
              done_q   <= 1'b1;
            end else if (op_b[0]) begin
              state_q <= ADD_S;
            end else begin
              state_q <= SHL_S;
            end
          end
        end
        ADD_S: begin
          prod_q  <= alu_out;
          state_q <= SHL_S;
        end
        SHL_S: begin
          mcand_q <= alu_out;
          state_q <= SHR_S;
        end
        SHR_S: begin
          mplier_q <= alu_out;
          cnt_q    <= cnt_q + 3'd1;
          if (shr_exit) begin
            state_q  <= DONE_S;
            result_q <= prod_q;
            done_q   <= 1'b1;
          end else if (alu_out[0]) begin
            state_q <= ADD_S;
          end else begin
            state_q <= SHL_S;
          end
        end
        DONE_S: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a behavioural ALU attached; results and done
// latency are predicted at start time and checked when done pulses.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit logging  = 0;

  logic [7:0] exp_q[$];
  int         lat_q[$];
  int         t0_q[$];
  logic [3:0] op_log[$];

  logic [7:0] e_res;
  int         e_lat;
  int         e_t0;

  alu_mul_seq #(.WIDTH(8), .ITERS(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Shared ALU: shifts move InputA by one bit position.
  always_comb begin
    case (alu_op)
      ADD:     alu_out = alu_a + alu_b;
      LSH:     alu_out = alu_a << 1;
      RSH:     alu_out = alu_a >> 1;
      default: alu_out = 8'h00;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] b);
    int k;
    int a;
    a = $countones(b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    if (b == 8'h00) return 1;
    k = 0;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
`else
    k = 8;
`endif
    return 2 * k + a + 1;
  endfunction

  // Scoreboard: pop one prediction per done pulse.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (logging && busy) op_log.push_back(alu_op);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_res = exp_q.pop_front();
          e_lat = lat_q.pop_front();
          e_t0  = t0_q.pop_front();
          check("result", {24'h0, result}, {24'h0, e_res});
          check("latency", cyc - e_t0, e_lat);
        end
      end
    end
  end

  // Driver: waits for IDLE, pulses start for one cycle, then scrambles operands.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] full;
    int guard;
    guard = 0;
    @(negedge Clk);
    while (busy && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 32'd0, 32'd1);
    full  = a * b;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back(full[7:0]);
    lat_q.push_back(exp_latency(b));
    t0_q.push_back(cyc);
    @(negedge Clk);
    start = 1'b0;
    op_a  = 8'($urandom_range(0, 255));
    op_b  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_all();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
      lat_q.delete();
      t0_q.delete();
    end
  endtask

  initial begin
    int dc;
    bit seen;
    logic [3:0] exp_ops[8];
    exp_ops = '{ADD, LSH, RSH, LSH, RSH, ADD, LSH, RSH};

    Reset = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_alu_op", alu_op, LSH);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    Reset = 1'b0;

    // 3*5 with opcode trace
    op_log.delete();
    logging = 1;
    do_mul(8'd3, 8'd5);
    wait_all();
    logging = 0;
    check("oplog_len_ge8", op_log.size() >= 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i < op_log.size()) check($sformatf("alu_op_%0d", i), op_log[i], exp_ops[i]);
    end

    // Boundary and overflow cases, back-to-back
    do_mul(8'd20, 8'd20);
    do_mul(8'hFF, 8'hFF);
    do_mul(8'd77, 8'h00);
    do_mul(8'd9, 8'h80);
    do_mul(8'd200, 8'h01);
    for (int i = 0; i < 6; i++) do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_all();

    // Start while busy and during DONE is ignored
    dc = done_cnt;
    do_mul(8'd3, 8'd5);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      check("busy_hold", busy, 1'b1);
      if (done) begin
        seen  = 1;
        start = 1'b1;
        op_a  = 8'd7;
        op_b  = 8'd7;
      end else if (i == 2) begin
        start = 1'b1;
        op_a  = 8'd9;
        op_b  = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    if (!seen) check("busy_test_timeout", 32'd0, 32'd1);
    check("start_in_done_ignored", busy, 1'b0);
    repeat (4) @(negedge Clk);
    check("still_idle", busy, 1'b0);
    check("single_done", done_cnt - dc, 1);

    // Reset during SHL of 3*5, then 2*3
    do_mul(8'd3, 8'd5);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 8'h00);
    Reset = 1'b0;
    exp_q.delete();
    lat_q.delete();
    t0_q.delete();
    dc = done_cnt;
    repeat (20) @(negedge Clk);
    check("no_done_after_rst", done_cnt - dc, 0);
    do_mul(8'd2, 8'd3);
    wait_all();
    check("final_result", result, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes an 8-bit unsigned product (low 8 bits) by driving the shared 8-bit ALU through ADD, LSH and RSH steps.
- Sits beside the ALU in the basic processor datapath. The control unit issues a start/done request, and this block owns the ALU input mux while busy.
- The ALU is instantiated one level up. This block only drives the ALU operands and opcode, and consumes the ALU result and Zero flag.

Parameters:
- WIDTH, 8, data width of operands, result and ALU ports.
- ITERS, 8, maximum shift-add iterations (equal to WIDTH).

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  request pulse, sampled only in IDLE
- op_a  input  WIDTH  multiplicand, latched on an accepted start
- op_b  input  WIDTH  multiplier, latched on an accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in the DONE state
- result  output  WIDTH  product mod 2^WIDTH, held until the next completion
- alu_a  output  WIDTH  ALU InputA drive
- alu_b  output  WIDTH  ALU InputB drive
- alu_op  output  4  ALU opcode drive, values from the shared op enum
- alu_out  input  WIDTH  ALU Out
- alu_zero  input  1  ALU Zero flag (Out == 0)

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, and takes effect at the next rising edge.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal prod/mcand/mplier/cnt=0.
- Reset mid-operation: IDLE on the next edge, no done pulse, result cleared to 0.
- Internal registers: prod, mcand, mplier (WIDTH each); cnt (3 bits).
- States:
  - IDLE: alu_op=LSH, alu_a=alu_b=0. On start, latch mcand<=op_a, mplier<=op_b, prod<=0, cnt<=0. Next state is ADD if op_b[0]=1, otherwise SHL.
  - ADD: alu_op=ADD, alu_a=prod, alu_b=mcand. prod<=alu_out. Next state SHL.
  - SHL: alu_op=LSH, alu_a=mcand, alu_b=0. mcand<=alu_out. Next state SHR.
  - SHR: alu_op=RSH, alu_a=mplier, alu_b=0. mplier<=alu_out, cnt<=cnt+1.
    - Exit condition: cnt==ITERS-1, or (early-exit enabled and alu_zero).
    - If exiting: DONE.
    - Otherwise: ADD if alu_out[0]=1, else SHL.
  - DONE: result<=prod (registered on entry, visible in the DONE cycle), done=1, alu drives as in IDLE. Next state IDLE.
- Combinational drives: all ALU drives are combinational from state and registers. The ALU is combinational, so every step takes exactly one cycle.
- Arithmetic: unsigned, modulo 2^WIDTH. Overflow is discarded silently.
- Busy/start rules:
  - start while busy (including the DONE cycle) is ignored.
  - Back-to-back operation: start in the cycle after done is accepted.
- Latency: done asserts 2*k + a + 1 cycles after the start edge.
  - k = iterations executed.
  - a = number of 1 bits consumed.
- op_b stability: op_a/op_b changes after acceptance have no effect.

Optional Feature:
- Macro ALU_MUL_EARLY_EXIT_EN.
- Defined:
  - SHR exits to DONE when alu_zero=1 (no multiplier bits remain).
  - op_b==0 at start goes IDLE->DONE directly with result 0.
- Undefined:
  - Always ITERS iterations. alu_zero is ignored.
  - op_b==0 runs 8 SHL/SHR pairs, done 17 cycles after start, result 0.
- Results are identical in both builds. Only latency differs.

Decomposition:
- Shared package definitions:
  - Existing 4-bit op enum: ADD, LSH, RSH are used.
  - New typedef mul_state_t {IDLE, ADD_S, SHL_S, SHR_S, DONE_S}.
- No sub-module. The iteration counter and datapath registers are inline.
- The ALU is shared through a mux in the parent, selected by busy.

Test Plan:
- op_a=3, op_b=5 with ALU attached:
  - Required: result=0x0F.
  - alu_op sequence ADD,LSH,RSH,LSH,RSH,ADD,LSH,RSH.
  - done 9 cycles after start with early-exit; 19 cycles without.
- op_a=20, op_b=20 -> result=0x90 (400 mod 256). Overflow discarded, no error flag.
- op_a=0xFF, op_b=0xFF -> result=0x01. 8 iterations, all with ADD; done 25 cycles after start in both builds.
- op_b=0 -> result=0.
  - Early-exit build: done the cycle after start.
  - Other build: done at start+17.
- start pulse while busy with different operands -> ignored. The first result completes unchanged, and busy never drops early.
- Reset asserted in SHL of a 3*5 run -> next edge: busy=0, done=0, result=0. A new start 2*3 completes with result=0x06.
